// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: shared encodings for the multi-cycle MUL/DIVU/REMU
// sequencer and the ALU it drives.
//   op_e       - operation requested by the core control unit
//   alu_ctrl_e - control field of the shared 32-bit ALU
//   state_e    - sequencer states
package alu_muldiv_seq_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ITER_DEF = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,  // low 32 bits of unsigned product
    OP_DIVU = 2'b01,  // unsigned quotient
    OP_REMU = 2'b10,  // unsigned remainder
    OP_ILL  = 2'b11   // reserved encoding, reported as illegal
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: start/done handshake between the core control unit
// (master) and the MUL/DIV sequencer (slave).
//   start     - request, sampled only while the sequencer is idle
//   op        - operation (see alu_muldiv_seq_pkg::op_e)
//   operand_a - multiplicand or dividend, captured on accepted start
//   operand_b - multiplier or divisor, captured on accepted start
//   busy      - high from the cycle after accept until done
//   done      - one-cycle pulse, result valid in the same cycle
//   result    - held until the next accepted start
//   illegal   - sticky with result, set for the reserved op encoding
interface alu_muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/alu_muldiv_seq_alu.sv
// alu_muldiv_seq_alu: the core's single-cycle 32-bit ALU, reused here by the
// multi-cycle sequencer.
//   ctrl_i   - 00 add, 01 sub, 10 and, 11 or
//   a_i, b_i - operands
//   result_o - combinational result
//   zero_o   - result equals zero
module alu_muldiv_seq_alu
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  alu_ctrl_e        ctrl_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic [XLEN-1:0]  result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned RV32M MUL / DIVU / REMU sequencer.
// Issues one operation per cycle to a shared ALU while busy: shift-add for
// MUL (low product, wraps mod 2^32) and restoring division for DIVU/REMU.
// A legal op with a nonzero divisor (or any MUL) takes ITER RUN cycles and
// pulses done ITER+1 cycles after accept; divide-by-zero and the reserved
// op finish with latency 1.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - slave side of alu_muldiv_seq_if (start/op/operands in,
//           busy/done/result/illegal out)
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave bus
);

  localparam int unsigned    CW   = $clog2(ITER);
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  // Sequencer state and registered outputs
  state_e          state_q;
  op_e             op_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  // Datapath registers, shared between the two algorithms:
  //   a_q   - multiplicand (MUL, shifts left) / dividend-then-quotient (DIV)
  //   b_q   - multiplier (MUL, shifts right) / divisor (DIV, constant)
  //   acc_q - product accumulator (MUL) / partial remainder (DIV)
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;

  // One-iteration next values
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] final_d;

  // Shared ALU
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero_unused;

  // Restoring-division trial: remainder shifted left with the next dividend
  // bit. The compare is done here on 33 bits since the ALU has no carry out.
  logic [XLEN:0]   rem_shift;
  logic            ge;

  op_e             op_in;
  assign op_in = op_e'(bus.op);

  alu_muldiv_seq_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .ctrl_i  (alu_ctrl),
    .a_i     (alu_a),
    .b_i     (alu_b),
    .result_o(alu_res),
    .zero_o  (alu_zero_unused)
  );

  always_comb begin
    rem_shift = {acc_q, a_q[XLEN-1]};
    ge        = (rem_shift >= {1'b0, b_q});

    // ALU is parked at add 0+0 outside RUN
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (state_q == ST_RUN) begin
      if (op_q == OP_MUL) begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = b_q[0] ? a_q : '0;
      end else begin
        alu_ctrl = ALU_SUB;
        alu_a    = rem_shift[XLEN-1:0];
        alu_b    = b_q;
      end
    end

    if (op_q == OP_MUL) begin
      acc_d = alu_res;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end else begin
      // When ge holds, rem_shift - divisor < divisor, so the 32-bit ALU
      // difference is exact.
      acc_d = ge ? alu_res : rem_shift[XLEN-1:0];
      a_d   = {a_q[XLEN-2:0], ge};
      b_d   = b_q;
    end

    // Result of the final iteration is loaded directly so that done and
    // result appear together in the cycle after the last iteration.
    final_d = (op_q == OP_DIVU) ? a_d : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q      <= op_in;
            count_q   <= '0;
            illegal_q <= (op_in == OP_ILL);
            if (op_in == OP_ILL) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_FINISH;
            end else if ((op_in != OP_MUL) && (bus.operand_b == '0)) begin
              result_q <= (op_in == OP_DIVU) ? '1 : bus.operand_a;
              done_q   <= 1'b1;
              state_q  <= ST_FINISH;
            end else begin
              a_q     <= bus.operand_a;
              b_q     <= bus.operand_b;
              acc_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          acc_q   <= acc_d;
          a_q     <= a_d;
          b_q     <= b_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_d;
            state_q  <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: self-checking bench for alu_muldiv_seq. Expected values
// come from plain integer arithmetic (product, quotient, remainder) and the
// documented latency rules.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  localparam int ITER = 32;
  localparam int WIN  = ITER + 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_muldiv_seq_if #(.XLEN(32)) bus ();

  alu_muldiv_seq #(.XLEN(32), .ITER(ITER)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [1:0] op);
    return (op == 2'b11);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    if (op == 2'b00) return ITER + 1;
    if ((op == 2'b01 || op == 2'b10) && b != 32'd0) return ITER + 1;
    return 1;
  endfunction

  // ---------------- stimulus driver / observer ----------------
  // Called one time unit after a rising edge with the sequencer idle.
  // Drives one start, then watches WIN cycles. Optionally pulses start again
  // during cycle glitch_cyc with different operands (must be ignored).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int glitch_cyc, input logic [1:0] gop,
                       input logic [31:0] ga, input logic [31:0] gb,
                       output int lat, output logic [31:0] res, output logic ill,
                       output int busy_cnt, output int pulses);
    lat = -1; res = '0; ill = 1'b0; busy_cnt = 0; pulses = 0;
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.op = 2'($urandom_range(3, 0));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    for (int c = 1; c <= WIN; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin
          lat = c; res = bus.result; ill = bus.illegal;
        end
      end
      bus.start = (c == glitch_cyc);
      if (c == glitch_cyc) begin
        bus.op = gop; bus.operand_a = ga; bus.operand_b = gb;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    rst_n = 1'b0;
    #22;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset result: got %h want 0", bus.result); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset illegal: got %b want 0", bus.illegal); end
  endtask

  task automatic test_mul();
    logic [31:0] ta [3];
    logic [31:0] tb_ [3];
    logic [31:0] te [3];
    int lat, bc, np; logic [31:0] res; logic ill;
    ta  = '{32'd7, 32'hFFFF_FFFF, 32'h0001_0000};
    tb_ = '{32'd6, 32'd2,         32'h0001_0000};
    te  = '{32'd42, 32'hFFFF_FFFE, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, ta[i], tb_[i], 0, 2'b00, '0, '0, lat, res, ill, bc, np);
      n_checks++; if (res !== te[i]) begin n_fail++; $display("FAIL mul[%0d] result: got %h want %h", i, res, te[i]); end
      n_checks++; if (lat != ITER + 1) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, ITER + 1); end
      n_checks++; if (bc != ITER) begin n_fail++; $display("FAIL mul[%0d] busy cycles: got %0d want %0d", i, bc, ITER); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL mul[%0d] done pulses: got %0d want 1", i, np); end
      n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL mul[%0d] illegal: got %b want 0", i, ill); end
    end
  endtask

  task automatic test_div();
    logic [1:0]  to [4];
    logic [31:0] ta [4];
    logic [31:0] tb_ [4];
    logic [31:0] te [4];
    int lat, bc, np; logic [31:0] res; logic ill;
    to  = '{2'b01, 2'b10, 2'b01, 2'b10};
    ta  = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000};
    tb_ = '{32'd7,   32'd7,   32'd1,         32'hFFFF_FFFF};
    te  = '{32'd14,  32'd2,   32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(to[i], ta[i], tb_[i], 0, 2'b00, '0, '0, lat, res, ill, bc, np);
      n_checks++; if (res !== te[i]) begin n_fail++; $display("FAIL div[%0d] result: got %h want %h", i, res, te[i]); end
      n_checks++; if (lat != ITER + 1) begin n_fail++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, ITER + 1); end
      n_checks++; if (bc != ITER) begin n_fail++; $display("FAIL div[%0d] busy cycles: got %0d want %0d", i, bc, ITER); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL div[%0d] done pulses: got %0d want 1", i, np); end
    end
  endtask

  task automatic test_special();
    logic [1:0]  to [5];
    logic [31:0] ta [5];
    logic [31:0] tb_ [5];
    logic [31:0] te [5];
    logic        ti [5];
    int          tl [5];
    int lat, bc, np; logic [31:0] res; logic ill;
    to  = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    ta  = '{32'd5, 32'd5, 32'h1234_5678, 32'd9, 32'd3};
    tb_ = '{32'd0, 32'd0, 32'h9ABC_DEF0, 32'd0, 32'd4};
    te  = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd12};
    ti  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tl  = '{1, 1, 1, 1, ITER + 1};
    for (int i = 0; i < 5; i++) begin
      issue(to[i], ta[i], tb_[i], 0, 2'b00, '0, '0, lat, res, ill, bc, np);
      n_checks++; if (res !== te[i]) begin n_fail++; $display("FAIL special[%0d] result: got %h want %h", i, res, te[i]); end
      n_checks++; if (ill !== ti[i]) begin n_fail++; $display("FAIL special[%0d] illegal: got %b want %b", i, ill, ti[i]); end
      n_checks++; if (lat != tl[i]) begin n_fail++; $display("FAIL special[%0d] latency: got %0d want %0d", i, lat, tl[i]); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL special[%0d] done pulses: got %0d want 1", i, np); end
      n_checks++; if (bc != ((tl[i] > 1) ? ITER : 0)) begin n_fail++; $display("FAIL special[%0d] busy cycles: got %0d", i, bc); end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bc, np; logic [31:0] res; logic ill;
    // Second request during RUN
    issue(2'b00, 32'd7, 32'd6, 10, 2'b01, 32'd1, 32'd1, lat, res, ill, bc, np);
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL ignore_run result: got %h want 0000002a", res); end
    n_checks++; if (np != 1) begin n_fail++; $display("FAIL ignore_run done pulses: got %0d want 1", np); end
    n_checks++; if (lat != ITER + 1) begin n_fail++; $display("FAIL ignore_run latency: got %0d want %0d", lat, ITER + 1); end
    // Second request during the done cycle
    issue(2'b01, 32'd100, 32'd7, ITER + 1, 2'b00, 32'd2, 32'd2, lat, res, ill, bc, np);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignore_done result: got %h want 0000000e", res); end
    n_checks++; if (np != 1) begin n_fail++; $display("FAIL ignore_done done pulses: got %0d want 1", np); end
    n_checks++; if (bus.result !== 32'd14) begin n_fail++; $display("FAIL ignore_done held result: got %h want 0000000e", bus.result); end
  endtask

  task automatic test_back_to_back();
    int          dcyc [$];
    logic [31:0] dres [$];
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd7; bus.operand_b = 32'd6;
    @(posedge clk); #1;
    bus.operand_a = 32'd9; bus.operand_b = 32'd9;
    for (int c = 1; c <= 2 * (ITER + 2) + 4; c++) begin
      if (bus.done) begin dcyc.push_back(c); dres.push_back(bus.result); end
      if (c == 2 * (ITER + 2) - 1) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    n_checks++; if (dcyc.size() != 2) begin n_fail++; $display("FAIL b2b pulse count: got %0d want 2", dcyc.size()); end
    if (dcyc.size() >= 2) begin
      n_checks++; if (dcyc[0] != ITER + 1) begin n_fail++; $display("FAIL b2b first done cycle: got %0d want %0d", dcyc[0], ITER + 1); end
      n_checks++; if (dcyc[1] != 2 * ITER + 3) begin n_fail++; $display("FAIL b2b second done cycle: got %0d want %0d", dcyc[1], 2 * ITER + 3); end
      n_checks++; if (dres[0] !== 32'd42) begin n_fail++; $display("FAIL b2b first result: got %h want 0000002a", dres[0]); end
      n_checks++; if (dres[1] !== 32'd81) begin n_fail++; $display("FAIL b2b second result: got %h want 00000051", dres[1]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, np; logic [31:0] res; logic ill;
    int pulses;
    issue(2'b00, 32'd7, 32'd6, 0, 2'b00, '0, '0, lat, res, ill, bc, np);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b want 0", bus.done); end
    n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL abort result: got %h want 0", bus.result); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL abort illegal: got %b want 0", bus.illegal); end
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    for (int c = 0; c < WIN; c++) begin
      if (bus.done || bus.busy) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort activity after reset: got %0d cycles want 0", pulses); end
    issue(2'b00, 32'd3, 32'd5, 0, 2'b00, '0, '0, lat, res, ill, bc, np);
    n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL abort followup result: got %h want 0000000f", res); end
    n_checks++; if (lat != ITER + 1) begin n_fail++; $display("FAIL abort followup latency: got %0d want %0d", lat, ITER + 1); end
  endtask

  task automatic test_random();
    int lat, bc, np; logic [31:0] res; logic ill;
    logic [1:0] op; logic [31:0] a, b;
    int el;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(3, 0));
      a  = $urandom;
      case ($urandom_range(3, 0))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15, 1));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      el = ref_latency(op, b);
      issue(op, a, b, 0, 2'b00, '0, '0, lat, res, ill, bc, np);
      n_checks++; if (res !== ref_result(op, a, b)) begin n_fail++; $display("FAIL rand[%0d] op=%0d a=%h b=%h result: got %h want %h", i, op, a, b, res, ref_result(op, a, b)); end
      n_checks++; if (ill !== ref_illegal(op)) begin n_fail++; $display("FAIL rand[%0d] illegal: got %b want %b", i, ill, ref_illegal(op)); end
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, el); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL rand[%0d] done pulses: got %0d want 1", i, np); end
      n_checks++; if (bc != ((el > 1) ? ITER : 0)) begin n_fail++; $display("FAIL rand[%0d] busy cycles: got %0d", i, bc); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
